// File: rtl/uart_pkg.sv
// Shared types and default constants for the UART transmit path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int UART_DATA_W       = 8;
  localparam int UART_CLKS_PER_BIT = 16;
  localparam int UART_CNT_W        = $clog2(UART_CLKS_PER_BIT);

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Byte-source handshake and serial-line status between the UART register block and the tx controller.
interface uart_tx_ctrl_if
  import uart_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W
);
  logic              tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              parity_en;
  logic              parity_odd;
  logic              tx_ready;
  logic              tx_busy;
  logic              tx_done;
  logic              tx_out;

  modport master (
    output tx_valid, tx_data, parity_en, parity_odd,
    input  tx_ready, tx_busy, tx_done, tx_out
  );

  modport slave (
    input  tx_valid, tx_data, parity_en, parity_odd,
    output tx_ready, tx_busy, tx_done, tx_out
  );
endinterface

// File: rtl/uart_tx_shift.sv
// Load/shift register of per-bit enable-gated flops; bit 0 is the data bit on the line.
module uart_tx_shift
  import uart_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W
) (
  input  logic              clk,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] din,
  output logic              data_bit_d
);
  logic [DATA_W-1:0] sr_q;
  logic [DATA_W-1:0] sr_d;
  logic              en;

  // Next contents: parallel load, or shift right with 1 filling from the top.
  always_comb begin
    en         = load | shift;
    sr_d       = load ? din : {1'b1, sr_q[DATA_W-1:1]};
    data_bit_d = en ? sr_d[0] : sr_q[0];
  end

  for (genvar i = 0; i < DATA_W; i++) begin : g_bit
    // Each stage only captures when the controller enables a load or shift.
    always_ff @(posedge clk) begin
      if (en) sr_q[i] <= sr_d[i];
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: baud timing, frame FSM and upstream handshake.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_W       = UART_DATA_W,
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_ctrl_if.slave  bus
);
  localparam int CNT_W = cnt_w(CLKS_PER_BIT);
  localparam int IDX_W = cnt_w(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  tx_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             par_en_q, par_en_d;
  logic             par_bit_q, par_bit_d;
  logic             tx_out_q, tx_out_d;
  logic             done_q, done_d;
  logic             bit_tick;
  logic             accept;
  logic             load;
  logic             shift;
  logic             data_bit_d;

  assign bit_tick     = (state_q != IDLE) && (cnt_q == CNT_LAST);
  assign bus.tx_ready = (state_q == IDLE) && !rst;
  assign accept       = bus.tx_valid && bus.tx_ready;
  assign bus.tx_busy  = (state_q != IDLE);
  assign bus.tx_done  = done_q;
  assign bus.tx_out   = tx_out_q;

  uart_tx_shift #(.DATA_W(DATA_W)) u_shift (
    .clk        (clk),
    .load       (load),
    .shift      (shift),
    .din        (bus.tx_data),
    .data_bit_d (data_bit_d)
  );

  // Frame sequencing, baud counter and the registered line value for next cycle.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    done_d    = 1'b0;
    load      = 1'b0;
    shift     = 1'b0;
    if (state_q == IDLE || bit_tick) cnt_d = '0;
    else                             cnt_d = cnt_q + 1'b1;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          load      = 1'b1;
          par_en_d  = bus.parity_en;
          par_bit_d = (^bus.tx_data) ^ bus.parity_odd;
          state_d   = START;
        end
      end
      START: begin
        if (bit_tick) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (bit_tick) begin
          shift = 1'b1;
          idx_d = idx_q + 1'b1;
          if (idx_q == IDX_LAST) state_d = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (bit_tick) state_d = STOP;
      end
      STOP: begin
        if (bit_tick) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    unique case (state_d)
      START:   tx_out_d = 1'b0;
      DATA:    tx_out_d = data_bit_d;
      PARITY:  tx_out_d = par_bit_q;
      default: tx_out_d = 1'b1;
    endcase
  end

  // Control state; reset aborts any frame and returns the line to idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      tx_out_q <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      tx_out_q <= tx_out_d;
      done_q   <= done_d;
    end
  end

  // Per-frame parity settings captured at acceptance; only read while a frame is active.
  always_ff @(posedge clk) begin
    par_en_q  <= par_en_d;
    par_bit_q <= par_bit_d;
  end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
- Transmit-side controller for the UART: sequences a bank of enable-gated single-bit registers, organised as a shift register, to serialise one byte per frame onto the line.
- Frame format: start bit, DATA_W data bits LSB first, optional parity bit, one stop bit.
- Owns baud timing (bit-period counter), the frame FSM and the valid/ready handshake with the upstream byte source.
- Sits between the UART top-level register interface and the tx pin.

Parameters:
- DATA_W, 8, data bits per frame (legal range 5..9).
- CLKS_PER_BIT, 16, clk cycles per serial bit (must be >= 2).

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  synchronous reset, active-high
- tx_valid  in  1  upstream byte available
- tx_data  in  DATA_W  byte to send; sampled on acceptance
- parity_en  in  1  append a parity bit; sampled on acceptance
- parity_odd  in  1  1 = odd parity, 0 = even; sampled on acceptance
- tx_ready  out  1  controller can accept a byte
- tx_busy  out  1  frame in progress
- tx_done  out  1  one-cycle pulse at frame completion
- tx_out  out  1  serial line (idle high)

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, counters=0, tx_out=1, tx_busy=0, tx_done=0. tx_ready is forced 0 while rst=1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Bit period: baud counter runs 0..CLKS_PER_BIT-1 in every non-IDLE state. bit_tick=1 when counter==CLKS_PER_BIT-1, after which the counter wraps to 0.
- IDLE:
  - tx_ready = 1; tx_out = 1.
  - When tx_valid & tx_ready at an edge: latch tx_data, parity_en and parity_odd; set the parity bit to (^data) XOR parity_odd; go to START with counter=0.
- START: tx_out=0 for CLKS_PER_BIT cycles. On bit_tick go to DATA with bit index=0.
- DATA:
  - tx_out = shift register bit 0.
  - On bit_tick, shift right by one and increment the index.
  - At index==DATA_W-1 with bit_tick, go to PARITY if the latched parity_en is 1, otherwise go to STOP.
- PARITY: tx_out = latched parity bit for one bit period, then go to STOP.
- STOP: tx_out=1 for one bit period. On bit_tick go to IDLE and assert tx_done for exactly that following cycle (its first IDLE cycle).
- Outputs are registered. tx_out changes exactly on bit boundaries with no glitches.
- Latency: byte accepted at edge N; tx_out=0 from cycle N+1. Frame length = (2+DATA_W+parity_en)*CLKS_PER_BIT cycles.
- tx_busy = 1 in every non-IDLE state. tx_ready = 0 whenever busy.
- Back-to-back: with tx_valid held, the next byte is accepted in the IDLE cycle coinciding with tx_done. This gives exactly 1 idle cycle at tx_out=1 between stop and the next start.
- tx_valid while busy is ignored; no queuing.
- tx_data and parity inputs may change after acceptance without affecting the frame in flight.
- Reset mid-frame: the frame aborts at that edge, tx_out=1 from the next cycle, and no tx_done is produced.

Decomposition:
- uart_pkg holds:
  - tx_state_t enum (IDLE, START, DATA, PARITY, STOP);
  - the default constants UART_DATA_W=8 and UART_CLKS_PER_BIT=16;
  - the bit-counter width derived via $clog2.
- Sub-module uart_tx_shift: a DATA_W-bit load/shift register built from per-bit enable-gated flops.
  - load: parallel load from tx_data.
  - shift: shift right, filling with 1.
  - Bit 0 drives the data-bit value.
- The controller drives load/shift enables only.

Test Plan (CLKS_PER_BIT=4, DATA_W=8):
- Reset then idle:
  - rst=1 for 3 cycles -> tx_out=1, tx_busy=0, tx_done=0, tx_ready=0.
  - After rst=0 -> tx_ready=1 on the next cycle.
- 0xA5, parity off, accepted at edge N:
  - tx_out over 4-cycle periods = 0 | 1,0,1,0,0,1,0,1 | 1.
  - tx_busy high for 40 cycles; tx_done pulses at cycle N+41.
- 0x07, parity_en=1:
  - parity_odd=0 -> parity bit 1.
  - parity_odd=1 -> parity bit 0.
  - Frame is 44 cycles in both cases.
- tx_valid held with 0x55 then 0xAA:
  - Two frames separated by exactly 1 idle cycle.
  - The second acceptance coincides with tx_done.
  - tx_data changed mid-frame does not corrupt the first frame.
- tx_valid pulsed with 0xFF during DATA of an ongoing frame -> ignored; tx_ready stays 0 and no second frame follows.
- rst=1 for 1 cycle during the DATA state of a frame:
  - tx_out=1 on the next cycle, state IDLE, no tx_done.
  - A new byte 0x3C then transmits correctly.
